// File: rtl/fft_frame_serializer.sv
// Ping-pong frame buffer that turns parallel FFT result frames into a
// two-sample-per-beat valid/ready stream; frames arriving with no free bank are dropped.
module fft_frame_serializer #(
    parameter int  N                 = 8,
    parameter int  ORDER             = 0,
    parameter int  BEAT_W            = $clog2(N) - 1,
    parameter type complex_product_t = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  complex_product_t [N-1:0]   in_frame,
    input  logic                       in_mode,
    output complex_product_t           out_data_0,
    output complex_product_t           out_data_1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BEAT_W-1:0]          out_beat,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic                       out_mode,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);
    localparam int                IDX_W     = $clog2(N);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N / 2 - 1);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_t;

    occ_t                     r_occ, w_occ_nxt;
    complex_product_t [N-1:0] r_bank [2];
    logic [1:0]               r_mode;
    logic                     r_wr_bank, r_rd_bank;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_overflow;
    logic [7:0]               r_drop_count;

    logic                     w_xfer, w_done, w_accept, w_drop;
    logic [IDX_W-1:0]         w_idx0, w_idx1;

    assign out_valid = (r_occ != S_EMPTY);
    assign w_xfer    = out_valid && out_ready;
    assign w_done    = w_xfer && (r_beat == LAST_BEAT);
    // A full buffer still takes a frame when the last beat frees a bank this cycle.
    assign w_accept  = in_valid && ((r_occ != S_TWO) || w_done);
    assign w_drop    = in_valid && (r_occ == S_TWO) && !w_done;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            S_EMPTY: if (w_accept) w_occ_nxt = S_ONE;
            S_ONE: begin
                if (w_accept && !w_done)      w_occ_nxt = S_TWO;
                else if (!w_accept && w_done) w_occ_nxt = S_EMPTY;
            end
            S_TWO:   if (w_done && !w_accept) w_occ_nxt = S_ONE;
            default: w_occ_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ        <= S_EMPTY;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_beat       <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_overflow <= w_drop;
            if (w_drop && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;
            if (w_accept)
                r_wr_bank <= ~r_wr_bank;
            if (w_xfer) begin
                r_beat <= w_done ? '0 : r_beat + 1'b1;
                if (w_done)
                    r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Bank storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_bank[r_wr_bank] <= in_frame;
            r_mode[r_wr_bank] <= in_mode;
        end
    end

    generate
        if (ORDER == 0) begin : g_adjacent
            assign w_idx0 = {r_beat, 1'b0};
            assign w_idx1 = {r_beat, 1'b1};
        end else begin : g_split
            assign w_idx0 = {1'b0, r_beat};
            assign w_idx1 = {1'b1, r_beat};
        end
    endgenerate

    always_comb begin
        out_data_0 = '0;
        out_data_1 = '0;
        out_beat   = '0;
        out_sof    = 1'b0;
        out_eof    = 1'b0;
        out_mode   = 1'b0;
        if (out_valid) begin
            out_data_0 = r_bank[r_rd_bank][w_idx0];
            out_data_1 = r_bank[r_rd_bank][w_idx1];
            out_beat   = r_beat;
            out_sof    = (r_beat == '0);
            out_eof    = (r_beat == LAST_BEAT);
            out_mode   = r_mode[r_rd_bank];
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: both lane orders side by side against a
// queue-based frame model, plus directed tables and corner sequences.
module tb_fft_frame_serializer;
    localparam int N    = 8;
    localparam int HALF = N / 2;
    localparam int BW   = $clog2(N) - 1;

    typedef struct packed {logic [15:0] re; logic [15:0] im;} cpx_t;
    typedef cpx_t [N-1:0] frame_t;
    typedef struct {frame_t f; logic m;} qent_t;
    typedef struct {
        logic iv; logic rdy; logic v; int b;
        int d0; int d1; int e0; int e1; logic sof; logic eof;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   reset, in_valid, in_mode, out_ready;
    frame_t in_frame;
    cpx_t   a_d0, a_d1, b_d0, b_d1;
    logic   a_v, a_sof, a_eof, a_m, a_ovf, b_v, b_sof, b_eof, b_m, b_ovf;
    logic [BW-1:0] a_b, b_b;
    logic [7:0]    a_dc, b_dc;

    fft_frame_serializer #(.N(N), .ORDER(0), .complex_product_t(cpx_t)) dut_adj (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame(in_frame), .in_mode(in_mode),
        .out_data_0(a_d0), .out_data_1(a_d1), .out_valid(a_v), .out_ready(out_ready),
        .out_beat(a_b), .out_sof(a_sof), .out_eof(a_eof), .out_mode(a_m),
        .overflow(a_ovf), .drop_count(a_dc));

    fft_frame_serializer #(.N(N), .ORDER(1), .complex_product_t(cpx_t)) dut_split (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame(in_frame), .in_mode(in_mode),
        .out_data_0(b_d0), .out_data_1(b_d1), .out_valid(b_v), .out_ready(out_ready),
        .out_beat(b_b), .out_sof(b_sof), .out_eof(b_eof), .out_mode(b_m),
        .overflow(b_ovf), .drop_count(b_dc));

    int errors = 0;
    int checks = 0;

    qent_t q[$];
    int    mbeat = 0;
    int    mdrop = 0;
    logic  movf  = 1'b0;
    vec_t  tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mkframe(input int base);
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i].re = 16'(base + i);
            f[i].im = 16'h0;
        end
        return f;
    endfunction

    function automatic frame_t rndframe();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = cpx_t'($urandom);
        return f;
    endfunction

    function automatic cpx_t re_only(input int v);
        cpx_t c;
        c.re = 16'(v);
        c.im = 16'h0;
        return c;
    endfunction

    task automatic check_model();
        cpx_t e00, e01, e10, e11;
        logic ev, em;
        int   eb;
        ev = (q.size() > 0);
        e00 = '0; e01 = '0; e10 = '0; e11 = '0; em = 1'b0; eb = 0;
        if (ev) begin
            eb  = mbeat;
            em  = q[0].m;
            e00 = q[0].f[2*mbeat];
            e01 = q[0].f[2*mbeat+1];
            e10 = q[0].f[mbeat];
            e11 = q[0].f[mbeat+HALF];
        end
        chk("m_valid_adj", a_v, ev);
        chk("m_valid_split", b_v, ev);
        chk("m_beat", a_b, eb);
        chk("m_sof", a_sof, ev && (eb == 0));
        chk("m_eof", a_eof, ev && (eb == HALF - 1));
        chk("m_mode", a_m, em);
        chk("m_adj_lane0", a_d0, e00);
        chk("m_adj_lane1", a_d1, e01);
        chk("m_split_lane0", b_d0, e10);
        chk("m_split_lane1", b_d1, e11);
        chk("m_split_beat", b_b, eb);
        chk("m_overflow", a_ovf, movf);
        chk("m_drop_count", a_dc, mdrop);
        chk("m_drop_count_split", b_dc, mdrop);
    endtask

    // Checks current outputs, applies one edge of stimulus, advances the model.
    task automatic step(input logic iv, input frame_t f, input logic md, input logic rdy, input logic rst);
        logic  done, xfer, acc;
        qent_t e;
        check_model();
        reset = rst; in_valid = iv; in_frame = f; in_mode = md; out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete(); mbeat = 0; mdrop = 0; movf = 1'b0;
        end else begin
            xfer = (q.size() > 0) && rdy;
            done = xfer && (mbeat == HALF - 1);
            acc  = iv && ((q.size() < 2) || done);
            movf = iv && !acc;
            if (movf && mdrop < 255) mdrop++;
            if (xfer) mbeat = done ? 0 : mbeat + 1;
            if (done) void'(q.pop_front());
            if (acc) begin
                e.f = f; e.m = md;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        // iv rdy | valid beat adj0 adj1 split0 split1 sof eof  (outputs after the edge)
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 0, 1, 2, 1, 5, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1, 3, 4, 2, 6, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2, 5, 6, 3, 7, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 3, 7, 8, 4, 8, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 0, 1, 2, 1, 5, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1, 3, 4, 2, 6, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2, 5, 6, 3, 7, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2, 5, 6, 3, 7, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2, 5, 6, 3, 7, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2, 5, 6, 3, 7, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 3, 7, 8, 4, 8, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_frame = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", a_v, 0);
        chk("reset_beat", a_b, 0);
        chk("reset_data", a_d0, 0);
        chk("reset_overflow", a_ovf, 0);
        chk("reset_drop_count", a_dc, 0);

        // Basic streaming in both orders, then a 3-cycle stall at beat 2.
        for (int r = 0; r < 13; r++) begin
            step(tbl[r].iv, mkframe(1), 1'b0, tbl[r].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", r), a_v, tbl[r].v);
            chk($sformatf("tbl%0d_beat", r), a_b, tbl[r].b);
            chk($sformatf("tbl%0d_adj0", r), a_d0, tbl[r].v ? re_only(tbl[r].d0) : '0);
            chk($sformatf("tbl%0d_adj1", r), a_d1, tbl[r].v ? re_only(tbl[r].d1) : '0);
            chk($sformatf("tbl%0d_split0", r), b_d0, tbl[r].v ? re_only(tbl[r].e0) : '0);
            chk($sformatf("tbl%0d_split1", r), b_d1, tbl[r].v ? re_only(tbl[r].e1) : '0);
            chk($sformatf("tbl%0d_sof", r), a_sof, tbl[r].sof);
            chk($sformatf("tbl%0d_eof", r), a_eof, tbl[r].eof);
        end

        // Three frames into a stalled consumer: third is dropped.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, mkframe(10), 1'b0, 1'b0, 1'b0); idle(1'b0, 4);
        step(1'b1, mkframe(20), 1'b1, 1'b0, 1'b0); idle(1'b0, 4);
        step(1'b1, mkframe(30), 1'b0, 1'b0, 1'b0);
        chk("drop_overflow_pulse", a_ovf, 1);
        chk("drop_count_one", a_dc, 1);
        idle(1'b0, 1);
        chk("drop_overflow_cleared", a_ovf, 0);
        for (int k = 0; k < 2 * HALF; k++) begin
            chk($sformatf("release_mode_%0d", k), a_m, (k < HALF) ? 1'b0 : 1'b1);
            idle(1'b1, 1);
        end
        chk("release_drained", a_v, 0);

        // Capture coincident with eof handshake while both banks are full.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, mkframe(40), 1'b0, 1'b0, 1'b0);
        step(1'b1, mkframe(50), 1'b1, 1'b0, 1'b0);
        idle(1'b1, HALF - 1);
        step(1'b1, mkframe(60), 1'b0, 1'b1, 1'b0);
        chk("coinc_no_overflow", a_ovf, 0);
        chk("coinc_drop_count", a_dc, 0);
        chk("coinc_second_mode", a_m, 1);
        chk("coinc_second_data", a_d0, re_only(50));
        idle(1'b1, HALF);
        chk("coinc_third_sof", a_sof, 1);
        chk("coinc_third_data", a_d1, re_only(61));
        idle(1'b1, HALF);
        chk("coinc_drained", a_v, 0);

        // Reset mid-frame with both banks full; in_valid during reset ignored.
        step(1'b1, mkframe(70), 1'b0, 1'b0, 1'b0);
        step(1'b1, mkframe(80), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);
        chk("midrst_at_beat1", a_b, 1);
        step(1'b1, mkframe(90), 1'b1, 1'b1, 1'b1);
        chk("midrst_valid", a_v, 0);
        chk("midrst_drop_count", a_dc, 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("midrst_still_empty", a_v, 0);
        step(1'b1, mkframe(100), 1'b1, 1'b1, 1'b0);
        chk("midrst_new_beat", a_b, 0);
        chk("midrst_new_data", a_d0, re_only(100));
        chk("midrst_new_mode", a_m, 1);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) step(1'b1, rndframe(), 1'($urandom), 1'b0, 1'b0);
        chk("drop_saturated", a_dc, 255);
        idle(1'b1, 2 * HALF + 2);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) == 0, rndframe(), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        check_model();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Frame-to-stream converter that sits directly downstream of the radix-2 FFT engine. It captures each parallel N-point result frame (`in_frame`, qualified by `in_valid`) into a two-deep ping-pong frame buffer. It streams the frame out as two complex samples per cycle over N/2 beats, using a valid/ready handshake, to the next consumer (equalizer, IFFT input, or host DMA). The FFT engine has no backpressure, so frames that arrive with both banks occupied are dropped and counted.

## Interface
Parameters:
- `N`, 8: FFT size; power of two, 8..256.
- `ORDER`, 0: lane pairing. 0 = adjacent (beat k carries X[2k], X[2k+1]); 1 = split (beat k carries X[k], X[k+N/2]).
- `BEAT_W`, $clog2(N)-1: width of the beat index (derived, not overridden).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  one-cycle strobe; `in_frame` holds a complete result frame.
- `in_frame`  in  complex_product_t [N-1:0]  natural-order FFT bins.
- `in_mode`  in  1  frame tag (FFT output_mode); stored with the frame.
- `out_data_0`  out  complex_product_t  lane 0 sample.
- `out_data_1`  out  complex_product_t  lane 1 sample.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts beat.
- `out_beat`  out  BEAT_W  beat index 0..N/2-1 within the frame.
- `out_sof`  out  1  high on beat 0.
- `out_eof`  out  1  high on beat N/2-1.
- `out_mode`  out  1  tag of the frame being streamed.
- `overflow`  out  1  one-cycle pulse when a frame is dropped.
- `drop_count`  out  8  saturating count of dropped frames.

## Operation
- Storage: two banks of N complex_product_t plus a 1-bit mode tag each. Control: `wr_bank`, `rd_bank`, `occ` (0..2), and `beat` (BEAT_W bits).
- Occupancy FSM:
  - EMPTY (occ=0) -> ONE on capture.
  - ONE -> TWO on capture without frame completion.
  - ONE -> EMPTY on completion without capture.
  - ONE -> ONE on capture and completion in the same cycle.
  - TWO -> ONE on completion.
- Capture: on `in_valid`, a frame is accepted if occ<2, or if occ==2 and the current beat completes the read frame (the last-beat handshake frees a bank in the same cycle). An accepted frame is written to `wr_bank`, and `wr_bank` toggles.
- Drop: `in_valid` with occ==2 and no same-cycle completion. Banks and the read stream are untouched, `overflow`=1 for that cycle, and `drop_count` increments, saturating at 255.
- Handshake: a beat transfers when `out_valid && out_ready`. On transfer, `beat` increments. On the transfer at beat N/2-1, `beat` wraps to 0, `rd_bank` toggles, and the frame completes.
- Output mux is combinational from `rd_bank` and `beat`. With ORDER=0: lane0=bank[2*beat], lane1=bank[2*beat+1]. With ORDER=1: lane0=bank[beat], lane1=bank[beat+N/2].
- `out_valid` = (occ>0). When out_valid=0, `out_data_*`, `out_beat`, `out_sof`, `out_eof`, and `out_mode` are driven 0.
- Stall: while `out_valid && !out_ready`, all out_* stay stable. A frame captured into the other bank during a stall does not disturb the streaming frame.
- No arithmetic is performed; samples pass bit-exact.

## Timing
- Reset values: occ=0, wr_bank=0, rd_bank=0, beat=0, out_valid=0, all out_data/beat/sof/eof/mode=0, overflow=0, drop_count=0.
- Reset mid-frame: all buffered frames are discarded, and out_valid=0 on the cycle after reset is sampled. `in_valid` during reset is ignored and not counted.
- Latency: `in_valid` at edge t with occ=0 -> out_valid=1, out_sof=1, and beat 0 data valid in cycle t+1.
- Throughput: with out_ready held 1, one frame every N/2 cycles with no bubbles between back-to-back frames (eof beat of frame A, then sof beat of frame B in the next cycle).
- `overflow` is asserted in the cycle following the dropping edge, as a registered one-cycle pulse.

## Test plan
- N=8, ORDER=0, frame X[i]=i+1 (real part, imag=0), out_ready=1 -> 4 beats starting 1 cycle after in_valid: (1,2),(3,4),(5,6),(7,8); sof on beat 0, eof on beat 3, then out_valid=0.
- Same frame with ORDER=1 -> beats (1,5),(2,6),(3,7),(4,8).
- out_ready low for 3 cycles at beat 2 -> beat 2 data held for 4 cycles, then beat 3; frame intact.
- out_ready=0, three frames (tags 0,1,0) issued 5 cycles apart -> first two buffered; third dropped with overflow pulse and drop_count=1. On release, frames stream in order with out_mode 0 then 1.
- occ=2, third in_valid coincident with the eof handshake of the read frame -> accepted (no overflow), streams after the second frame.
- Reset asserted at beat 1 with occ=2 -> out_valid=0 next cycle; drop_count=0; a new frame after reset streams from beat 0.
